// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges one cacheline transfer from the cache to a multi-beat burst on the
// physical memory port, assembling read beats into a line and slicing a write line into beats.
module cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64,
    parameter int s_addr  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [s_line-1:0] line_i,
    output logic [s_line-1:0] line_o,
    input  logic [s_addr-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [s_addr-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);
    localparam int num_beats = s_line / s_burst;
    localparam int cnt_w     = $clog2(num_beats);
    localparam int off_w     = $clog2(s_line / 8);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t             r_state;
    logic [cnt_w-1:0]   r_cnt;
    logic [s_line-1:0]  r_line;
    logic [s_line-1:0]  r_wline;
    logic [s_addr-1:0]  r_addr;
    logic               r_read;
    logic               r_write;
    logic               r_resp;
    logic               w_last;
    logic               w_addr_unused;

    // The byte offset within a line never reaches memory; bursts are always line-aligned.
    assign w_addr_unused = ^address_i[off_w-1:0];
    assign w_last        = resp_i && (r_cnt == cnt_w'(num_beats - 1));

    assign line_o    = r_line;
    assign address_o = r_addr;
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign resp_o    = r_resp;
    assign burst_o   = (r_state == WR_BURST) ? r_wline[s_burst*r_cnt +: s_burst] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
            r_wline <= '0;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_resp  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_resp <= 1'b0;
                    if (write_i || read_i) begin
                        r_addr  <= {address_i[s_addr-1:off_w], off_w'(0)};
                        r_cnt   <= '0;
                        r_state <= write_i ? WR_BURST : RD_BURST;
                        r_write <= write_i;
                        r_read  <= !write_i;
                        if (write_i) r_wline <= line_i;
                    end
                end
                RD_BURST: if (resp_i) begin
                    r_line[s_burst*r_cnt +: s_burst] <= burst_i;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_read  <= 1'b0;
                        r_resp  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                WR_BURST: if (resp_i) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_write <= 1'b0;
                        r_resp  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_resp  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: scenario tasks drive cacheline transfers against a memory model that
// records the beats it returns and the words it expects, and checks every cycle of each burst.
module tb_cacheline_adaptor;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i, line_o;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, resp_o;
    logic [63:0]  burst_i, burst_o;
    logic         read_o, write_o, resp_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] fixed_beats[4];
    bit          use_fixed = 0;
    bit          pat[$];

    cacheline_adaptor dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
        .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i),
        .burst_o(burst_o), .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // One whole transfer as the cache sees it. gap_mode: 0 no gaps, 1 random gaps, 2 use pat.
    // abort_at >= 0 asserts rst once that many beats have been accepted.
    task automatic run_txn(input bit wr, input bit both, input logic [31:0] addr,
                           input logic [255:0] line, input int gap_mode, input int abort_at);
        logic [255:0] exp_line = line_o;
        logic [31:0]  exp_addr = addr & 32'hFFFF_FFE0;
        logic [63:0]  beat;
        int k = 0, cyc = 0, gaps = 0;
        bit acc;
        read_i = !wr || both; write_i = wr; address_i = addr; line_i = line; resp_i = 0;
        @(negedge clk);
        while (k < 4 && cyc < 200) begin
            n_checks++;
            if (address_o !== exp_addr) begin n_fail++; $display("FAIL addr_o k=%0d got %h exp %h", k, address_o, exp_addr); end
            n_checks++;
            if (read_o !== !wr || write_o !== wr) begin n_fail++; $display("FAIL req_o k=%0d got rd=%b wr=%b exp rd=%b wr=%b", k, read_o, write_o, !wr, wr); end
            n_checks++;
            if (burst_o !== (wr ? line[64*k +: 64] : 64'h0)) begin n_fail++; $display("FAIL burst_o k=%0d got %h exp %h", k, burst_o, wr ? line[64*k +: 64] : 64'h0); end
            n_checks++;
            if (resp_o !== 1'b0) begin n_fail++; $display("FAIL early_resp k=%0d got %b exp 0", k, resp_o); end
            if (abort_at == k) begin
                rst = 1; #1;
                n_checks++;
                if ({line_o, address_o, read_o, write_o, resp_o, burst_o} !== '0) begin
                    n_fail++; $display("FAIL async_rst got line=%h addr=%h rd=%b wr=%b resp=%b exp all 0", line_o, address_o, read_o, write_o, resp_o);
                end
                read_i = 0; write_i = 0; resp_i = 0;
                @(negedge clk);
                rst = 0;
                repeat (2) begin
                    @(negedge clk);
                    n_checks++;
                    if (resp_o !== 1'b0 || read_o !== 1'b0) begin n_fail++; $display("FAIL aborted_resp got resp=%b rd=%b exp 0 0", resp_o, read_o); end
                end
                return;
            end
            acc = (gap_mode == 0) ? 1'b1 : (gap_mode == 2 && pat.size() > 0) ? pat.pop_front() : ($urandom_range(0, 2) != 0);
            beat = use_fixed ? fixed_beats[k] : {$urandom, $urandom};
            resp_i = acc; burst_i = beat;
            if (acc && !wr) exp_line[64*k +: 64] = beat;
            address_i = $urandom; line_i = rand_line();
            @(negedge clk);
            cyc++;
            if (acc) k++; else gaps++;
        end
        resp_i = 0;
        n_checks++;
        if (k != 4) begin n_fail++; $display("FAIL timeout got %0d beats exp 4", k); end
        n_checks++;
        if (resp_o !== 1'b1) begin n_fail++; $display("FAIL resp_o got %b exp 1", resp_o); end
        n_checks++;
        if (cyc != 4 + gaps) begin n_fail++; $display("FAIL latency got %0d exp %0d", cyc, 4 + gaps); end
        n_checks++;
        if (read_o !== 1'b0 || write_o !== 1'b0 || burst_o !== 64'h0) begin n_fail++; $display("FAIL done_outs got rd=%b wr=%b burst=%h exp 0", read_o, write_o, burst_o); end
        n_checks++;
        if (line_o !== exp_line) begin n_fail++; $display("FAIL line_o got %h exp %h", line_o, exp_line); end
        n_checks++;
        if (address_o !== exp_addr) begin n_fail++; $display("FAIL addr_hold got %h exp %h", address_o, exp_addr); end
        read_i = 0; write_i = 0;
        @(negedge clk);
        n_checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin n_fail++; $display("FAIL resp_pulse got resp=%b rd=%b wr=%b exp 0 0 0", resp_o, read_o, write_o); end
        n_checks++;
        if (line_o !== exp_line) begin n_fail++; $display("FAIL line_stable got %h exp %h", line_o, exp_line); end
    endtask

    task automatic test_reset();
        rst = 1; read_i = 0; write_i = 0; resp_i = 0; address_i = 0; line_i = 0; burst_i = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({line_o, address_o, read_o, write_o, resp_o, burst_o} !== '0) begin n_fail++; $display("FAIL reset_state got line=%h addr=%h rd=%b wr=%b resp=%b exp all 0", line_o, address_o, read_o, write_o, resp_o); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_read_nogap();
        fixed_beats[0] = 64'h1111_1111_1111_1111; fixed_beats[1] = 64'h2222_2222_2222_2222;
        fixed_beats[2] = 64'h3333_3333_3333_3333; fixed_beats[3] = 64'h4444_4444_4444_4444;
        use_fixed = 1;
        run_txn(0, 0, 32'h0000_1234, '0, 0, -1);
        use_fixed = 0;
        n_checks++;
        if (line_o !== {fixed_beats[3], fixed_beats[2], fixed_beats[1], fixed_beats[0]}) begin n_fail++; $display("FAIL read_line got %h", line_o); end
        n_checks++;
        if (address_o !== 32'h0000_1220) begin n_fail++; $display("FAIL read_addr got %h exp 00001220", address_o); end
    endtask

    task automatic test_write_gap();
        pat = '{1, 0, 1, 1, 1};
        run_txn(1, 0, 32'h0000_8008, 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0, 2, -1);
    endtask

    task automatic test_simultaneous();
        run_txn(1, 1, 32'hCAFE_F00D, rand_line(), 1, -1);
    endtask

    task automatic test_reset_mid();
        run_txn(0, 0, 32'h0000_3000, '0, 0, 2);
        run_txn(0, 0, 32'h0000_0040, '0, 1, -1);
    endtask

    task automatic test_idle_resp();
        logic [31:0] a = address_o;
        resp_i = 1; address_i = $urandom; line_i = rand_line();
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (read_o !== 0 || write_o !== 0 || resp_o !== 0 || address_o !== a) begin n_fail++; $display("FAIL idle_resp got rd=%b wr=%b resp=%b addr=%h exp 0 0 0 %h", read_o, write_o, resp_o, address_o, a); end
        end
        resp_i = 0;
        run_txn(1, 0, 32'h1234_5678, rand_line(), 1, -1);
    endtask

    task automatic test_back_to_back();
        run_txn(0, 0, 32'h0000_0100, '0, 0, -1);
        run_txn(1, 0, 32'h0000_0200, rand_line(), 0, -1);
        for (int i = 0; i < 10; i++)
            run_txn($urandom_range(0, 1), $urandom_range(0, 1), $urandom, rand_line(), 1, -1);
    endtask

    initial begin
        test_reset();
        test_read_nogap();
        test_write_gap();
        test_simultaneous();
        test_reset_mid();
        test_idle_resp();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
Downstream neighbour of the cache datapath. It converts one 256-bit cacheline transfer from the cache into a 4-beat × 64-bit burst on the physical memory port.
- Read: collects 4 beats from memory into a line and returns it to the cache.
- Write: splits the cache's line into 4 beats and sends them to memory.
- Sits between the cache's pmem_* interface and main memory; handles one transaction at a time.

Parameters:
s_line, 256, cacheline width in bits
s_burst, 64, memory beat width in bits
s_addr, 32, address width
num_beats, s_line/s_burst = 4, beats per line; derived, not overridable

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
line_i  input  256  line to write, from cache (pmem_wdata)
line_o  output  256  assembled read line, to cache (pmem_rdata)
address_i  input  32  line address from cache (pmem_address)
read_i  input  1  cache line read request
write_i  input  1  cache line write request
resp_o  output  1  transaction complete; one-cycle pulse
burst_i  input  64  read beat from memory
burst_o  output  64  write beat to memory
address_o  output  32  line-aligned address to memory
read_o  output  1  memory read request
write_o  output  1  memory write request
resp_i  input  1  memory beat accept/valid

Behaviour:
Reset (asynchronous, any state, including mid-burst):
- state=IDLE, beat counter=0.
- line_o, address_o, read_o, write_o, resp_o = 0; internal write-line register = 0.
- An aborted transaction is dropped; no resp_o is issued for it.

States: IDLE, RD_BURST, WR_BURST, DONE.

IDLE:
- read_i/write_i are sampled only in this state.
- write_i=1 → WR_BURST. Write wins if both are high.
- else read_i=1 → RD_BURST.
- On either transition, at the same edge:
  - latch address_o = {address_i[31:5], 5'b0};
  - clear counter;
  - for a write, latch line_i into the write-line register.
- resp_i is ignored in IDLE.

RD_BURST:
- read_o=1 (registered; asserted the cycle after the request is taken).
- On each edge with resp_i=1: line_o[64*k +: 64] <= burst_i, where k = counter; then k increments.
- Edges with resp_i=0 are gap cycles: hold state and counter, do not write line_o.
- On the edge accepting beat k=3: read_o drops, state → DONE.

WR_BURST:
- write_o=1; burst_o = write-line register[64*k +: 64] (combinational from counter).
- On each edge with resp_i=1, k increments; gaps behave as for reads.
- On the edge accepting k=3: write_o drops, state → DONE.

DONE:
- resp_o=1 for exactly this one cycle; line_o holds the complete line (read) and stays stable until the next read's first beat.
- Unconditional → IDLE next edge.
- The cache is required to drop read_i/write_i on the edge it sees resp_o.

Other rules:
- Latency, no gaps: request edge → read_o/write_o high next cycle → 4 resp_i cycles → resp_o in the following cycle. Total 6 cycles from the request edge to resp_o, inclusive.
- Counter is 2 bits; it wraps 3→0 only on completion, never mid-burst.
- address_o is held constant for the whole burst.
- read_o and write_o are never both high.
- burst_o = 0 outside WR_BURST.
- Request changes (read_i, write_i, address_i, line_i) during a burst have no effect.

Test Plan:
1. Read, no gaps: read_i=1, address_i=0x0000_1234; memory returns beats 0x1111..., 0x2222..., 0x3333..., 0x4444... on 4 consecutive resp_i cycles → address_o=0x0000_1220, read_o high 4 cycles, resp_o pulse of 1 cycle, line_o = {0x4444..., 0x3333..., 0x2222..., 0x1111...}.
2. Write, with gap: write_i=1, line_i = 256'h0123...CDEF, resp_i pattern 1,0,1,1,1 → burst_o is word0 until first accept, holds word1 through the gap, exactly 4 words emitted in order, write_o low afterward, single resp_o.
3. Simultaneous read_i=1 and write_i=1 in IDLE → write burst only; read_o stays 0 throughout.
4. rst asserted after beat 2 of a read → outputs 0 immediately (asynchronously), no resp_o; a following read of 0x0000_0040 completes normally with a fresh line_o.
5. resp_i pulsed while IDLE, and address_i/line_i changed mid-burst → no state change in IDLE; the burst uses the latched address and data.
6. Back-to-back: read immediately followed by write (cache re-requests in the cycle after resp_o) → second transaction starts from IDLE; counter is 0 and address_o is updated.
